// File: rtl/seq_comparator.sv
// Multi-cycle magnitude comparator: walks the operands SLICE bits per clock,
// MSB slice first, exits early on the first unequal slice, else falls to the cascade inputs.
module seq_comparator #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned SLICE  = 2,
    parameter int unsigned SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Gt_I,
    input  logic             Eq_I,
    input  logic             Lt_I,
    output logic             busy,
    output logic             done,
    output logic             Gt,
    output logic             Eq,
    output logic             Lt
);

    localparam int unsigned NS = WIDTH / SLICE;
    localparam int unsigned KW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [KW-1:0] K_TOP = KW'(NS - 1);
    // Flipping the sign bit of both operands turns a two's-complement compare
    // into an unsigned one; only the top slice is affected.
    localparam logic [WIDTH-1:0] SIGN_FLIP = (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

    typedef enum logic [0:0] {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [KW-1:0]    k;
    logic [KW-1:0]    k_n;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       cas_q;
    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic             load;
    logic             gt_n;
    logic             eq_n;
    logic             lt_n;
    logic             done_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            Gt    <= 1'b0;
            Eq    <= 1'b0;
            Lt    <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            k     <= k_n;
            Gt    <= gt_n;
            Eq    <= eq_n;
            Lt    <= lt_n;
            done  <= done_n;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            a_q   <= a ^ SIGN_FLIP;
            b_q   <= b ^ SIGN_FLIP;
            cas_q <= {Gt_I, Eq_I, Lt_I};
        end
    end

    always_comb begin
        state_n = state;
        k_n     = k;
        gt_n    = Gt;
        eq_n    = Eq;
        lt_n    = Lt;
        done_n  = 1'b0;
        load    = 1'b0;
        busy    = (state == RUN);
        slice_a = a_q[k*SLICE +: SLICE];
        slice_b = b_q[k*SLICE +: SLICE];

        case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    k_n     = K_TOP;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (slice_a != slice_b) begin
                    gt_n    = (slice_a > slice_b);
                    lt_n    = (slice_a < slice_b);
                    eq_n    = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (k != '0) begin
                    k_n = k - 1'b1;
                end else begin
                    // Priority-normalised cascade: Gt_I, then Lt_I, else equal.
                    casez (cas_q)
                        3'b1??: begin
                            gt_n = 1'b1;
                            eq_n = 1'b0;
                            lt_n = 1'b0;
                        end
                        3'b0?1: begin
                            gt_n = 1'b0;
                            eq_n = 1'b0;
                            lt_n = 1'b1;
                        end
                        default: begin
                            gt_n = 1'b0;
                            eq_n = 1'b1;
                            lt_n = 1'b0;
                        end
                    endcase
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_seq_comparator.sv
// Directed bench for seq_comparator (8-bit, 2-bit slices) with an unsigned and a signed
// instance; expected results and latencies are queued at launch and checked on done.
module tb_seq_comparator;

    localparam int unsigned W  = 8;
    localparam int unsigned SL = 2;
    localparam int unsigned NS = W / SL;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_u = 1'b0;
    logic         start_s = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         gi = 1'b0;
    logic         ei = 1'b0;
    logic         li = 1'b0;
    logic         busy_u, done_u, gt_u, eq_u, lt_u;
    logic         busy_s, done_s, gt_s, eq_s, lt_s;

    typedef struct {
        bit         sel;
        logic [2:0] res;
        int         m;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_comparator #(.WIDTH(W), .SLICE(SL), .SIGNED(0)) u_uns (
        .clk(clk), .rst(rst), .start(start_u), .a(a), .b(b),
        .Gt_I(gi), .Eq_I(ei), .Lt_I(li),
        .busy(busy_u), .done(done_u), .Gt(gt_u), .Eq(eq_u), .Lt(lt_u)
    );

    seq_comparator #(.WIDTH(W), .SLICE(SL), .SIGNED(1)) u_sgn (
        .clk(clk), .rst(rst), .start(start_s), .a(a), .b(b),
        .Gt_I(gi), .Eq_I(ei), .Lt_I(li),
        .busy(busy_s), .done(done_s), .Gt(gt_s), .Eq(eq_s), .Lt(lt_s)
    );

    // {busy, done, Gt, Eq, Lt}
    function automatic logic [4:0] obs(input bit sel);
        return sel ? {busy_s, done_s, gt_s, eq_s, lt_s}
                   : {busy_u, done_u, gt_u, eq_u, lt_u};
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic exp_t model(input bit sel, input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic [2:0] cas, input string tag);
        exp_t         e;
        logic [W-1:0] x;
        int           top;
        bit           greater;
        x   = av ^ bv;
        top = -1;
        for (int i = 0; i < NS; i++) begin
            if (x[i*SL +: SL] != '0) top = i;
        end
        e.sel = sel;
        e.tag = tag;
        e.m   = (top < 0) ? NS : NS - top;
        greater = sel ? ($signed(av) > $signed(bv)) : (av > bv);
        if (av == bv)
            e.res = cas[2] ? 3'b100 : (cas[0] ? 3'b001 : 3'b010);
        else
            e.res = greater ? 3'b100 : 3'b001;
        return e;
    endfunction

    task automatic launch(input bit sel, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [2:0] cas, input string tag);
        logic [4:0] o;
        a = av;
        b = bv;
        {gi, ei, li} = cas;
        if (sel) start_s = 1'b1; else start_u = 1'b1;
        sb_q.push_back(model(sel, av, bv, cas, tag));
        @(posedge clk); #1;
        start_s = 1'b0;
        start_u = 1'b0;
        o = obs(sel);
        check({tag, "_busy_acc"}, 32'(o[4]), 32'd1);
        check({tag, "_done_acc"}, 32'(o[3]), 32'd0);
    endtask

    task automatic wait_result(input int n0);
        exp_t       e;
        logic [4:0] o;
        int         n;
        e = sb_q.pop_front();
        n = n0;
        o = obs(e.sel);
        while (!o[3] && n < NS + 3) begin
            @(posedge clk); #1;
            n++;
            o = obs(e.sel);
            if (!o[3]) check({e.tag, "_busy_run"}, 32'(o[4]), 32'd1);
        end
        check({e.tag, "_done"}, 32'(o[3]), 32'd1);
        check({e.tag, "_latency"}, 32'(n), 32'(e.m));
        check({e.tag, "_result"}, 32'(o[2:0]), 32'(e.res));
        check({e.tag, "_busy_done"}, 32'(o[4]), 32'd0);
    endtask

    task automatic hold(input bit sel, input logic [2:0] res, input string tag);
        logic [4:0] o;
        @(posedge clk); #1;
        o = obs(sel);
        check({tag, "_done_pulse"}, 32'(o[3]), 32'd0);
        check({tag, "_hold"}, 32'(o[2:0]), 32'(res));
        check({tag, "_idle"}, 32'(o[4]), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_uns", 32'(obs(1'b0)), 32'd0);
        check("reset_sgn", 32'(obs(1'b1)), 32'd0);
        rst = 1'b0;

        launch(1'b0, 8'hC5, 8'h45, 3'b010, "early");
        wait_result(0);
        hold(1'b0, 3'b100, "early");

        launch(1'b0, 8'h12, 8'h13, 3'b010, "lsb");
        wait_result(0);
        hold(1'b0, 3'b001, "lsb");

        launch(1'b0, 8'hA5, 8'hA5, 3'b010, "eq_cas_eq");
        wait_result(0);
        hold(1'b0, 3'b010, "eq_cas_eq");
        launch(1'b0, 8'hA5, 8'hA5, 3'b001, "eq_cas_lt");
        wait_result(0);
        launch(1'b0, 8'hA5, 8'hA5, 3'b101, "eq_cas_gtlt");
        wait_result(0);
        launch(1'b0, 8'hA5, 8'hA5, 3'b000, "eq_cas_none");
        wait_result(0);

        launch(1'b1, 8'h80, 8'h01, 3'b010, "s_neg");
        wait_result(0);
        hold(1'b1, 3'b001, "s_neg");
        launch(1'b1, 8'hFF, 8'hFE, 3'b010, "s_lsb");
        wait_result(0);
        hold(1'b1, 3'b100, "s_lsb");

        // Second start while busy must be ignored; latency betrays a re-latch.
        launch(1'b0, 8'h01, 8'h00, 3'b010, "ignore");
        a       = 8'hFF;
        start_u = 1'b1;
        @(posedge clk); #1;
        start_u = 1'b0;
        a       = 8'h00;
        check("ignore_busy", 32'(busy_u), 32'd1);
        wait_result(1);
        hold(1'b0, 3'b100, "ignore");

        launch(1'b0, 8'h30, 8'h20, 3'b010, "b2b_first");
        wait_result(0);
        launch(1'b0, 8'h20, 8'h30, 3'b010, "b2b_second");
        wait_result(0);
        hold(1'b0, 3'b001, "b2b_second");

        launch(1'b0, 8'h00, 8'h00, 3'b010, "abort");
        void'(sb_q.pop_back());
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_clear", 32'(obs(1'b0)), 32'd0);
        for (int i = 0; i < NS + 1; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", 32'(done_u), 32'd0);
        end
        check("abort_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
